imm_issue_ctrl: RTL and testbench
=================================

// Module: imm_issue_ctrl
// PURPOSE
//  Decode-stage sequencer for the immediate generator. Accepts fetched instructions over valid/ready.
//  Classifies the opcode into the 3-bit immediate-select code and drives the imm generator's sel/instr inputs.
//  Tracks the generator's 1-cycle registered latency, so ex_valid_o is always aligned with its imm_o.
//  Holds the generator inputs stable under execute back-pressure. Sits between fetch and execute.
// PARAMETERS
//  XLEN   32  instruction/PC width (only 32 supported)
// PORTS
//  clk            in   1     single clock, all flops rising edge
//  rst            in   1     asynchronous, active-low reset
//  if_valid_i     in   1     fetch presents instruction
//  if_ready_o     out  1     controller accepts this cycle
//  if_instr_i     in   XLEN  fetched instruction
//  if_pc_i        in   XLEN  PC of fetched instruction
//  flush_i        in   1     kill all in-flight instructions (branch/trap redirect)
//  imm_sel_o      out  3     to imm generator sel_i (imm_sel_t code)
//  imm_instr_o    out  XLEN  to imm generator imm_i
//  ex_valid_o     out  1     execute slot valid; imm generator imm_o valid this cycle
//  ex_ready_i     in   1     execute consumes slot
//  ex_instr_o     out  XLEN  instruction matching current imm_o
//  ex_pc_o        out  XLEN  PC matching current imm_o
// BEHAVIOUR
//  Two stages: S1 (decoded, registered sel) and S2 (mirrors what the imm generator holds).
//  adv = ~s2_v | ex_ready_i. if_ready_o = (~s1_v | adv) & ~flush_i.
//  Accept edge: s1 <= {instr, pc, decode(instr[6:0])}, s1_v <= 1.
//  Advance: on adv, s2 <= s1 and s2_v <= s1_v; otherwise S1 and S2 hold.
//  S1 is cleared (s1_v <= 0) when it moves to S2 and no new accept occurs.
//  Gen inputs (comb): {imm_sel_o, imm_instr_o} = adv ? s1 : s2. The imm generator therefore registers the value S2 holds next cycle.
//  While stalled, imm_o recomputes the S2 instruction and stays stable. ex_ready_i -> imm_sel_o is a combinational path.
//  Latency: 2 cycles from accept to ex_valid_o. Throughput: 1 instruction/cycle.
//  Full with ~ex_ready_i: if_ready_o = 0, all outputs hold.
//  Simultaneous accept + advance in the same cycle is legal: S1 is refilled and S2 is loaded.
//  Decode map:
//    OP-IMM 0010011 -> 1 REGIMM
//    LOAD 0000011 -> 2
//    STORE 0100011 -> 3
//    BRANCH 1100011 -> 4
//    JALR 1100111 -> 5
//    JAL 1101111 -> 6
//    LUI 0110111 / AUIPC 0010111 -> 7 UPPER
//    OP 0110011 / FENCE 0001111 / SYSTEM 1110011 -> 0 DEFAULT
//    any other opcode: illegal, sel 0
//  flush_i: next edge s1_v = s2_v = 0. No accept in the flush cycle. flush_i has priority over adv/accept.
//  Reset (rst = 0, async): s1_v = s2_v = 0, all data regs 0, imm_sel_o = 0, imm_instr_o = 0, ex_valid_o = 0, ex_instr_o = 0, ex_pc_o = 0.
//  if_ready_o = 1 one cycle after reset release. Reset mid-stream discards everything; no partial handshake completes.
//  ex_* data outputs are don't-care when ex_valid_o = 0, but are driven from S2 (no X).
// CONFIGURATION
//  IMM_ILLEGAL_TRAP_EN defined:
//    adds port ex_illegal_o (out, 1), carried through S1/S2 and aligned with ex_valid_o.
//    Asserted for unmapped opcodes and for instr[1:0] != 2'b11. Reset value 0.
//  IMM_ILLEGAL_TRAP_EN undefined:
//    port absent; illegal opcodes silently issue with sel 0 (DEFAULT).
// STRUCTURE
//  Package rv_imm_pkg:
//    imm_sel_t typedef enum logic [2:0]: DEFAULT=0, REGIMM, LOAD, STORE, BRANCH, JALR, JAL, UPPER=7
//    localparam opcode constants OPC_*
//  Sub-module imm_sel_decode (combinational): opcode[6:0] -> imm_sel_t plus illegal flag.
//  imm_issue_ctrl instantiates imm_sel_decode and contains only the S1/S2 regs, handshake and mux.
// TESTING
//  1. Reset release, then ADDI x1,x0,-1 (0xFFF00093) accepted at cycle 0, ex_ready = 1:
//     imm_sel_o = 1 at cycle 1; ex_valid_o = 1 at cycle 2 with generator imm_o = 0xFFFFFFFF and ex_pc_o = accepted PC.
//  2. Back-to-back SW (0x00112623), BEQ (0x00208463), JAL (0x008000EF), LUI (0x123450B7):
//     sels 3, 4, 6, 7 issue on consecutive cycles; 4 consecutive ex_valid_o cycles.
//  3. ex_ready = 0 for 5 cycles with S1 and S2 full:
//     if_ready_o = 0, ex_instr_o and imm_o constant for all 5 cycles; on release the order is preserved with no loss or duplication.
//  4. flush_i with both stages full:
//     ex_valid_o = 0 next cycle, if_ready_o = 0 during the flush cycle, the next accepted instruction appears 2 cycles after accept.
//  5. Opcode 0x7F: with IMM_ILLEGAL_TRAP_EN, ex_illegal_o = 1 and sel = 0; without the macro, it issues normally with sel = 0.
//  6. Assert rst low while S2 is valid and ex_ready_i = 0: ex_valid_o drops asynchronously, imm_sel_o = 0, no instruction reissues after release.

Source files
------------

// File: rtl/rv_imm_pkg.sv
// Shared types for the immediate-generator issue path: select codes and RV32 opcodes.
package rv_imm_pkg;

  typedef enum logic [2:0] {
    DEFAULT = 3'd0,
    REGIMM  = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    BRANCH  = 3'd4,
    JALR    = 3'd5,
    JAL     = 3'd6,
    UPPER   = 3'd7
  } imm_sel_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_sel_decode.sv
// Opcode -> immediate select classifier. Illegal flag exists only with IMM_ILLEGAL_TRAP_EN.
module imm_sel_decode
  import rv_imm_pkg::*;
(
  input  logic [6:0] opcode,
`ifdef IMM_ILLEGAL_TRAP_EN
  output logic       illegal,
`endif
  output imm_sel_t   sel
);

  logic unmapped;

  always_comb begin
    sel      = DEFAULT;
    unmapped = 1'b0;
    case (opcode)
      OPC_OP_IMM:                     sel = REGIMM;
      OPC_LOAD:                       sel = LOAD;
      OPC_STORE:                      sel = STORE;
      OPC_BRANCH:                     sel = BRANCH;
      OPC_JALR:                       sel = JALR;
      OPC_JAL:                        sel = JAL;
      OPC_LUI, OPC_AUIPC:             sel = UPPER;
      OPC_OP, OPC_FENCE, OPC_SYSTEM:  sel = DEFAULT;
      default:                        unmapped = 1'b1;
    endcase
  end

`ifdef IMM_ILLEGAL_TRAP_EN
  // Every mapped opcode ends in 2'b11; the explicit check keeps compressed encodings flagged.
  assign illegal = unmapped | (opcode[1:0] != 2'b11);
`else
  logic unused_unmapped;
  assign unused_unmapped = unmapped;
`endif

endmodule

// File: rtl/imm_issue_ctrl.sv
// Two-stage decode sequencer feeding the registered imm generator; ex_valid_o aligns with imm_o.
// Optional IMM_ILLEGAL_TRAP_EN adds ex_illegal_o carried alongside each instruction.
module imm_issue_ctrl
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [XLEN-1:0] if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic            flush_i,
  output imm_sel_t        imm_sel_o,
  output logic [XLEN-1:0] imm_instr_o,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_instr_o,
`ifdef IMM_ILLEGAL_TRAP_EN
  output logic            ex_illegal_o,
`endif
  output logic [XLEN-1:0] ex_pc_o
);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    imm_sel_t        sel;
`ifdef IMM_ILLEGAL_TRAP_EN
    logic            illegal;
`endif
  } stage_t;

  stage_t   s1, s2, s_in;
  logic     s1_v, s2_v;
  logic     adv, accept;
  imm_sel_t dec_sel;

  imm_sel_decode u_dec (
    .opcode  (if_instr_i[6:0]),
`ifdef IMM_ILLEGAL_TRAP_EN
    .illegal (s_in.illegal),
`endif
    .sel     (dec_sel)
  );

  always_comb begin
    s_in.instr = if_instr_i;
    s_in.pc    = if_pc_i;
    s_in.sel   = dec_sel;
  end

  assign adv        = ~s2_v | ex_ready_i;
  assign if_ready_o = (~s1_v | adv) & ~flush_i;
  assign accept     = if_valid_i & if_ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else if (flush_i) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (adv) begin
        s2   <= s1;
        s2_v <= s1_v;
      end
      if (accept) begin
        s1   <= s_in;
        s1_v <= 1'b1;
      end else if (adv) begin
        s1_v <= 1'b0;
      end
    end
  end

  // Generator registers whatever S2 will hold after this edge, so imm_o tracks S2 exactly.
  assign imm_sel_o   = adv ? s1.sel   : s2.sel;
  assign imm_instr_o = adv ? s1.instr : s2.instr;

  assign ex_valid_o = s2_v;
  assign ex_instr_o = s2.instr;
  assign ex_pc_o    = s2.pc;
`ifdef IMM_ILLEGAL_TRAP_EN
  assign ex_illegal_o = s2.illegal;
`endif

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Directed bench for imm_issue_ctrl with a behavioural registered immediate generator.
module tb_imm_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i, if_ready_o, flush_i, ex_valid_o, ex_ready_i;
  logic [31:0] if_instr_i, if_pc_i, imm_instr_o, ex_instr_o, ex_pc_o;
  logic [2:0]  imm_sel_o;
`ifdef IMM_ILLEGAL_TRAP_EN
  logic        ex_illegal_o;
`endif
  logic [31:0] imm_q;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  imm_issue_ctrl #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid_i  (if_valid_i),
    .if_ready_o  (if_ready_o),
    .if_instr_i  (if_instr_i),
    .if_pc_i     (if_pc_i),
    .flush_i     (flush_i),
    .imm_sel_o   (imm_sel_o),
    .imm_instr_o (imm_instr_o),
    .ex_valid_o  (ex_valid_o),
    .ex_ready_i  (ex_ready_i),
    .ex_instr_o  (ex_instr_o),
`ifdef IMM_ILLEGAL_TRAP_EN
    .ex_illegal_o(ex_illegal_o),
`endif
    .ex_pc_o     (ex_pc_o)
  );

  // Reference immediate generator (RV32I formats), one registered stage.
  function automatic logic [31:0] gen_imm(input logic [2:0] sel, input logic [31:0] i);
    case (sel)
      3'd1, 3'd2, 3'd5: gen_imm = {{20{i[31]}}, i[31:20]};
      3'd3:             gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd4:             gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd6:             gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd7:             gen_imm = {i[31:12], 12'b0};
      default:          gen_imm = 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) imm_q <= 32'd0;
    else      imm_q <= gen_imm(imm_sel_o, imm_instr_o);

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid_i = v; if_instr_i = instr; if_pc_i = pc;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1; drive(1'b0, 32'd0, 32'd0);
    repeat (3) next_cyc();
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %0b exp 0", ex_valid_o); end
    n_chk++; if (imm_sel_o !== 3'd0) begin n_fail++; $display("FAIL reset_imm_sel got %0d exp 0", imm_sel_o); end
    n_chk++; if ({imm_instr_o, ex_instr_o, ex_pc_o} !== 96'd0) begin n_fail++; $display("FAIL reset_data got %h %h %h exp 0", imm_instr_o, ex_instr_o, ex_pc_o); end
    rst = 1'b1;
    next_cyc();
    n_chk++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready got %0b exp 1", if_ready_o); end
  endtask

  task automatic test_addi();
    drive(1'b1, 32'hFFF00093, 32'h0000_0100);
    next_cyc();
    drive(1'b0, 32'd0, 32'd0); #1;
    n_chk++; if (imm_sel_o !== 3'd1) begin n_fail++; $display("FAIL addi_sel got %0d exp 1", imm_sel_o); end
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL addi_early_valid got %0b exp 0", ex_valid_o); end
    next_cyc();
    n_chk++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %0b exp 1", ex_valid_o); end
    n_chk++; if (imm_q !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm got %h exp ffffffff", imm_q); end
    n_chk++; if (ex_pc_o !== 32'h100) begin n_fail++; $display("FAIL addi_pc got %h exp 00000100", ex_pc_o); end
`ifdef IMM_ILLEGAL_TRAP_EN
    n_chk++; if (ex_illegal_o !== 1'b0) begin n_fail++; $display("FAIL addi_illegal got %0b exp 0", ex_illegal_o); end
`endif
    next_cyc();
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %0b exp 0", ex_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4] = '{32'h00112623, 32'h00208463, 32'h008000EF, 32'h123450B7};
    logic [2:0]  sel [4] = '{3'd3, 3'd4, 3'd6, 3'd7};
    logic [31:0] imm [4] = '{32'h0000000C, 32'h00000008, 32'h00000008, 32'h12345000};
    int run = 0;
    drive(1'b1, ins[0], 32'h200);
    for (int k = 0; k < 6; k++) begin
      next_cyc();
      if (k < 3) drive(1'b1, ins[k+1], 32'h200 + 32'(4*(k+1)));
      else       drive(1'b0, 32'd0, 32'd0);
      #1;
      if (k < 4) begin
        n_chk++; if (imm_sel_o !== sel[k]) begin n_fail++; $display("FAIL b2b_sel[%0d] got %0d exp %0d", k, imm_sel_o, sel[k]); end
      end
      if (ex_valid_o) run++;
      if (k >= 1 && k <= 4) begin
        n_chk++; if (imm_q !== imm[k-1] || ex_instr_o !== ins[k-1]) begin n_fail++; $display("FAIL b2b_issue[%0d] got imm %h instr %h exp %h %h", k-1, imm_q, ex_instr_o, imm[k-1], ins[k-1]); end
      end
    end
    n_chk++; if (run != 4) begin n_fail++; $display("FAIL b2b_valid_count got %0d exp 4", run); end
  endtask

  task automatic test_stall();
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h00500093, 32'h300); next_cyc();
    drive(1'b1, 32'hFFC12083, 32'h304); next_cyc();
    drive(1'b1, 32'h01008067, 32'h308);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_if_ready[%0d] got %0b exp 0", i, if_ready_o); end
      n_chk++; if (ex_valid_o !== 1'b1 || ex_instr_o !== 32'h00500093 || imm_q !== 32'd5) begin n_fail++; $display("FAIL stall_hold[%0d] got v %0b instr %h imm %h exp 1 00500093 00000005", i, ex_valid_o, ex_instr_o, imm_q); end
      n_chk++; if (imm_sel_o !== 3'd1) begin n_fail++; $display("FAIL stall_sel[%0d] got %0d exp 1", i, imm_sel_o); end
      if (i < 4) next_cyc();
    end
    ex_ready_i = 1'b1; #1;
    n_chk++; if (if_ready_o !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %0b exp 1", if_ready_o); end
    next_cyc(); drive(1'b0, 32'd0, 32'd0); #1;
    n_chk++; if (ex_valid_o !== 1'b1 || ex_instr_o !== 32'hFFC12083 || imm_q !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL stall_second got v %0b instr %h imm %h exp 1 ffc12083 fffffffc", ex_valid_o, ex_instr_o, imm_q); end
    next_cyc();
    n_chk++; if (ex_valid_o !== 1'b1 || ex_instr_o !== 32'h01008067 || imm_q !== 32'd16) begin n_fail++; $display("FAIL stall_third got v %0b instr %h imm %h exp 1 01008067 00000010", ex_valid_o, ex_instr_o, imm_q); end
    next_cyc();
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_no_dup got %0b exp 0", ex_valid_o); end
  endtask

  task automatic test_flush();
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h00500093, 32'h400); next_cyc();
    drive(1'b1, 32'hFFC12083, 32'h404); next_cyc();
    drive(1'b1, 32'h01008067, 32'h408); flush_i = 1'b1; ex_ready_i = 1'b1; #1;
    n_chk++; if (if_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_if_ready got %0b exp 0", if_ready_o); end
    next_cyc(); flush_i = 1'b0; drive(1'b0, 32'd0, 32'd0); #1;
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid got %0b exp 0", ex_valid_o); end
    next_cyc();
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_s1_cleared got %0b exp 0", ex_valid_o); end
    drive(1'b1, 32'h123450B7, 32'h500); next_cyc();
    drive(1'b0, 32'd0, 32'd0); #1;
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_post_early got %0b exp 0", ex_valid_o); end
    next_cyc();
    n_chk++; if (ex_valid_o !== 1'b1 || ex_instr_o !== 32'h123450B7 || imm_q !== 32'h12345000 || ex_pc_o !== 32'h500) begin n_fail++; $display("FAIL flush_post got v %0b instr %h imm %h pc %h exp 1 123450b7 12345000 00000500", ex_valid_o, ex_instr_o, imm_q, ex_pc_o); end
    next_cyc();
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h0000007F, 32'h600); next_cyc();
    drive(1'b0, 32'd0, 32'd0); #1;
    n_chk++; if (imm_sel_o !== 3'd0) begin n_fail++; $display("FAIL illegal_sel got %0d exp 0", imm_sel_o); end
    next_cyc();
    n_chk++; if (ex_valid_o !== 1'b1 || ex_instr_o !== 32'h0000007F) begin n_fail++; $display("FAIL illegal_issue got v %0b instr %h exp 1 0000007f", ex_valid_o, ex_instr_o); end
`ifdef IMM_ILLEGAL_TRAP_EN
    n_chk++; if (ex_illegal_o !== 1'b1) begin n_fail++; $display("FAIL illegal_flag got %0b exp 1", ex_illegal_o); end
`endif
    next_cyc();
  endtask

  task automatic test_reset_midstream();
    ex_ready_i = 1'b0;
    drive(1'b1, 32'h00500093, 32'h700); next_cyc();
    drive(1'b1, 32'hFFC12083, 32'h704); next_cyc();
    drive(1'b0, 32'd0, 32'd0); #2;
    rst = 1'b0; #1;
    n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got %0b exp 0", ex_valid_o); end
    n_chk++; if (imm_sel_o !== 3'd0) begin n_fail++; $display("FAIL rst_async_sel got %0d exp 0", imm_sel_o); end
    next_cyc(); rst = 1'b1; ex_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      n_chk++; if (ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_reissue[%0d] got %0b exp 0", i, ex_valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
